// File: rtl/i2c_register_target_if.sv
// Register-target bus bundle: static address, sampled SCL, status and write-commit strobe.
// SDA stays a plain inout on the target because it is an open-drain net.
interface i2c_register_target_if;
  logic [6:0] device_address;
  logic       external_serial_clock;
  logic       busy;
  logic       register_write_strobe;
  logic [7:0] register_write_address;
  logic [7:0] register_write_data;

  modport master (
    output device_address, external_serial_clock,
    input  busy, register_write_strobe, register_write_address, register_write_data
  );

  modport slave (
    input  device_address, external_serial_clock,
    output busy, register_write_strobe, register_write_address, register_write_data
  );
endinterface

// File: rtl/i2c_register_target.sv
// I2C target with an 8-bit register bank; oversamples SCL/SDA and never stretches SCL.
// Define I2C_TARGET_AUTO_INCREMENT_EN to advance the register pointer after every data byte.
module i2c_register_target #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned REGISTER_WIDTH = 8,
  parameter int unsigned REGISTER_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  inout  wire                  external_serial_data,
  i2c_register_target_if.slave bus
);

`ifdef I2C_TARGET_AUTO_INCREMENT_EN
  localparam bit AUTO_INCREMENT = 1'b1;
`else
  localparam bit AUTO_INCREMENT = 1'b0;
`endif

  localparam int unsigned INDEX_WIDTH = (REGISTER_DEPTH > 1) ? $clog2(REGISTER_DEPTH) : 1;
  localparam logic [3:0]  BYTE_BITS   = 4'(DATA_WIDTH);

  localparam logic [3:0] IDLE         = 4'd0;
  localparam logic [3:0] ADDRESS      = 4'd1;
  localparam logic [3:0] ADDRESS_ACK  = 4'd2;
  localparam logic [3:0] REGISTER     = 4'd3;
  localparam logic [3:0] REGISTER_ACK = 4'd4;
  localparam logic [3:0] WRITE_DATA   = 4'd5;
  localparam logic [3:0] WRITE_ACK    = 4'd6;
  localparam logic [3:0] READ_DATA    = 4'd7;
  localparam logic [3:0] READ_ACK     = 4'd8;
  localparam logic [3:0] WAIT_STOP    = 4'd9;

  logic [3:0]                state;
  logic                      scl_meta, scl_sync, scl_prev;
  logic                      sda_meta, sda_sync, sda_prev;
  logic                      scl_rise, scl_fall, start_seen, stop_seen;
  logic                      sda_drive_low;
  logic                      busy_q, strobe_q, read_not_write, write_pending;
  logic [3:0]                bit_count;
  logic [DATA_WIDTH-1:0]     shift_reg, write_data_q;
  logic [REGISTER_WIDTH-1:0] pointer, write_address_q;
  logic [INDEX_WIDTH-1:0]    index;
  logic [DATA_WIDTH-1:0]     bank [REGISTER_DEPTH];

  assign external_serial_data       = sda_drive_low ? 1'b0 : 1'bz;
  assign bus.busy                   = busy_q;
  assign bus.register_write_strobe  = strobe_q;
  assign bus.register_write_address = write_address_q;
  assign bus.register_write_data    = write_data_q;
  assign index                      = pointer[INDEX_WIDTH-1:0];

  // Synchronizers reset high so an idle bus produces no spurious edge when reset is released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      {scl_meta, scl_sync, scl_prev} <= '1;
      {sda_meta, sda_sync, sda_prev} <= '1;
    end else begin
      {scl_meta, scl_sync, scl_prev} <= {bus.external_serial_clock, scl_meta, scl_sync};
      {sda_meta, sda_sync, sda_prev} <= {external_serial_data, sda_meta, sda_sync};
    end
  end

  assign scl_rise   = scl_sync & ~scl_prev;
  assign scl_fall   = ~scl_sync & scl_prev;
  assign start_seen = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_seen  = scl_sync & scl_prev & ~sda_prev & sda_sync;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      sda_drive_low   <= 1'b0;
      busy_q          <= 1'b0;
      strobe_q        <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      pointer         <= '0;
      shift_reg       <= '0;
      bit_count       <= '0;
      read_not_write  <= 1'b0;
      write_pending   <= 1'b0;
      bank            <= '{default: '0};
    end else begin
      strobe_q <= 1'b0;
      if (start_seen) begin
        state         <= ADDRESS;
        bit_count     <= '0;
        sda_drive_low <= 1'b0;
        write_pending <= 1'b0;
      end else if (stop_seen) begin
        state         <= IDLE;
        sda_drive_low <= 1'b0;
        busy_q        <= 1'b0;
        write_pending <= 1'b0;
      end else begin
        case (state)
          ADDRESS, REGISTER: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[DATA_WIDTH-2:0], sda_sync};
              bit_count <= bit_count + 4'd1;
            end else if (scl_fall && bit_count == BYTE_BITS) begin
              if (state == REGISTER) begin
                pointer       <= shift_reg;
                sda_drive_low <= 1'b1;
                state         <= REGISTER_ACK;
              end else if (shift_reg[DATA_WIDTH-1:1] == bus.device_address) begin
                read_not_write <= shift_reg[0];
                busy_q         <= 1'b1;
                sda_drive_low  <= 1'b1;
                state          <= ADDRESS_ACK;
              end else begin
                state <= IDLE;
              end
            end
          end
          ADDRESS_ACK: begin
            if (scl_fall) begin
              bit_count <= '0;
              if (read_not_write) begin
                shift_reg     <= bank[index];
                sda_drive_low <= ~bank[index][DATA_WIDTH-1];
                state         <= READ_DATA;
              end else begin
                sda_drive_low <= 1'b0;
                state         <= REGISTER;
              end
            end
          end
          REGISTER_ACK, WRITE_ACK: begin
            if (scl_fall) begin
              sda_drive_low <= 1'b0;
              bit_count     <= '0;
              state         <= WRITE_DATA;
            end
          end
          WRITE_DATA: begin
            // Commit one cycle after the last data rise, well before the ACK phase starts.
            if (scl_rise) begin
              shift_reg     <= {shift_reg[DATA_WIDTH-2:0], sda_sync};
              bit_count     <= bit_count + 4'd1;
              write_pending <= (bit_count == BYTE_BITS - 4'd1);
            end else if (write_pending) begin
              write_pending   <= 1'b0;
              bank[index]     <= shift_reg;
              strobe_q        <= 1'b1;
              write_address_q <= pointer;
              write_data_q    <= shift_reg;
              if (AUTO_INCREMENT) pointer <= pointer + REGISTER_WIDTH'(1);
            end else if (scl_fall && bit_count == BYTE_BITS) begin
              sda_drive_low <= 1'b1;
              state         <= WRITE_ACK;
            end
          end
          READ_DATA: begin
            if (scl_rise) begin
              bit_count <= bit_count + 4'd1;
            end else if (scl_fall) begin
              if (bit_count == BYTE_BITS) begin
                sda_drive_low <= 1'b0;
                state         <= READ_ACK;
              end else begin
                shift_reg     <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                sda_drive_low <= ~shift_reg[DATA_WIDTH-2];
              end
            end
          end
          READ_ACK: begin
            if (scl_rise) begin
              bit_count <= BYTE_BITS + 4'd1;
              if (AUTO_INCREMENT) pointer <= pointer + REGISTER_WIDTH'(1);
              if (sda_sync) begin
                busy_q <= 1'b0;
                state  <= WAIT_STOP;
              end
            end else if (scl_fall && bit_count == BYTE_BITS + 4'd1) begin
              shift_reg     <= bank[index];
              sda_drive_low <= ~bank[index][DATA_WIDTH-1];
              bit_count     <= '0;
              state         <= READ_DATA;
            end
          end
          IDLE, WAIT_STOP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
